i2c_slave_ctrl: RTL

- Byte-level I2C target controller sitting directly downstream of the I2C bit-level bus interface.
- Consumes received bytes and START/STOP indications, matches the 7-bit device address and manages a register pointer.
- Performs auto-incrementing writes into and reads from the LED driver register file.
- Feeds read bytes back to the bus interface through its tx_data/tx_req/tx_ready handshake and requests ACK generation.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_ptr_ctr.sv | 27 ++
 rtl/i2c_slave_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types, constants and pointer-wrap helper for the I2C target controller
package i2c_pkg;

   localparam int I2C_ADDR_BITS = 7;
   localparam logic I2C_RW_READ = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_PTR,
      ST_WRITE,
      ST_READ,
      ST_IGNORE
   } i2c_ctrl_state_t;

   // Next register pointer with wrap back to 0 after the last register
   function automatic int ptr_wrap(input int p, input int n);
      return (p >= n - 1) ? 0 : p + 1;
   endfunction

endpackage

// File: rtl/i2c_ptr_ctr.sv
// rtl/i2c_ptr_ctr.sv - register pointer with load, increment and wrap at NUM_REGS-1
module i2c_ptr_ctr
   import i2c_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              inc,
   output logic [ADDR_W-1:0] ptr
);

   // Load has priority over increment; both are mutually exclusive in practice
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (load) begin
         ptr <= load_val;
      end else if (inc) begin
         ptr <= ADDR_W'(ptr_wrap(int'(32'(ptr)), NUM_REGS));
      end
   end

endmodule

// File: rtl/i2c_slave_ctrl.sv
// rtl/i2c_slave_ctrl.sv - byte-level I2C target controller with auto-incrementing register access
module i2c_slave_ctrl
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_BITS-1:0] DEV_ADDR = 7'h60,
   parameter int                       NUM_REGS = 16,
   parameter int                       ADDR_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              start_det,
   input  logic              stop_det,
   input  logic              mst_ack_valid,
   input  logic              mst_nack,
   output logic [7:0]        tx_data,
   output logic              tx_req,
   input  logic              tx_ready,
   output logic              ack_req,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_we,
   input  logic [7:0]        reg_rdata,
   output logic              busy
);

   i2c_ctrl_state_t state;

   logic addr_match;
   logic ptr_in_range;
   logic bus_event;
   logic ptr_load;
   logic read_accept;
   logic ptr_inc;

   // Decode of the current byte and of the pointer update strobes
   always_comb begin
      addr_match   = (rx_data[7:1] == DEV_ADDR);
      ptr_in_range = ({24'd0, rx_data} < 32'(NUM_REGS));
      bus_event    = stop_det | start_det;
      ptr_load     = !bus_event && (state == ST_PTR) && rx_valid && ptr_in_range;
      read_accept  = !bus_event && (state == ST_READ) && tx_req && tx_ready;
      // reg_we is registered, so the pointer advances at the end of the write
      // strobe cycle and reg_addr still shows the written address during it
      ptr_inc      = reg_we | read_accept;
   end

   i2c_ptr_ctr #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_ptr (
      .clk      (clk),
      .reset    (reset),
      .load     (ptr_load),
      .load_val (rx_data[ADDR_W-1:0]),
      .inc      (ptr_inc),
      .ptr      (reg_addr)
   );

   assign busy = (state != ST_IDLE);

   // Control FSM: bus events first, then per-state byte / master-ack handling
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         tx_data   <= '0;
         tx_req    <= 1'b0;
         ack_req   <= 1'b0;
         reg_we    <= 1'b0;
         reg_wdata <= '0;
      end else begin
         ack_req <= 1'b0;
         reg_we  <= 1'b0;
         if (tx_req && tx_ready) begin
            tx_req <= 1'b0;
         end

         if (stop_det) begin
            state  <= ST_IDLE;
            tx_req <= 1'b0;
         end else if (start_det) begin
            state  <= ST_ADDR;
            tx_req <= 1'b0;
         end else begin
            case (state)
               ST_ADDR: begin
                  if (rx_valid) begin
                     if (!addr_match) begin
                        state <= ST_IGNORE;
                     end else if (rx_data[0] == I2C_RW_READ) begin
                        ack_req <= 1'b1;
                        state   <= ST_READ;
                        tx_req  <= 1'b1;
                        tx_data <= reg_rdata;
                     end else begin
                        ack_req <= 1'b1;
                        state   <= ST_PTR;
                     end
                  end
               end
               ST_PTR: begin
                  if (rx_valid) begin
                     if (ptr_in_range) begin
                        ack_req <= 1'b1;
                        state   <= ST_WRITE;
                     end else begin
                        state <= ST_IGNORE;
                     end
                  end
               end
               ST_WRITE: begin
                  if (rx_valid) begin
                     reg_we    <= 1'b1;
                     reg_wdata <= rx_data;
                     ack_req   <= 1'b1;
                  end
               end
               ST_READ: begin
                  // Our own transmitted bits come back on rx_valid; ignore them
                  if (mst_ack_valid) begin
                     if (mst_nack) begin
                        state  <= ST_IGNORE;
                        tx_req <= 1'b0;
                     end else if (!tx_req) begin
                        tx_req  <= 1'b1;
                        tx_data <= reg_rdata;
                     end
                  end
               end
               default: begin
                  // IDLE and IGNORE wait for a bus event only
               end
            endcase
         end
      end
   end

endmodule
